// File: rtl/stim_sequencer.sv
// rtl/stim_sequencer.sv - programmable stimulation pulse-train sequencer
// Optional biphasic NEG phase and stim_neg output enabled by STIM_BIPHASIC_EN.
module stim_sequencer #(
   parameter int CNT_W = 16,
   parameter int NUM_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_we,
   input  logic [1:0]       cfg_addr,
   input  logic [CNT_W-1:0] cfg_wdata,
   input  logic             start,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic             stim_out,
`ifdef STIM_BIPHASIC_EN
   output logic             stim_neg,
`endif
   output logic [NUM_W-1:0] pulse_idx
);

   localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);
   localparam logic [NUM_W-1:0] ONE_N = NUM_W'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DELAY,
      S_PULSE,
      S_GAP,
      S_DONE
`ifdef STIM_BIPHASIC_EN
      , S_NEG
`endif
   } state_t;

   state_t           state_q;
   logic [CNT_W-1:0] width_q, width_d;
   logic [CNT_W-1:0] gap_q, gap_d;
   logic [NUM_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] delay_q, delay_d;

   logic [CNT_W-1:0] width_sh_q;
   logic [CNT_W-1:0] gap_rl_sh_q;
   logic [NUM_W-1:0] last_idx_sh_q;
   logic [CNT_W-1:0] cnt_q;
   logic [NUM_W-1:0] idx_q;
   logic             busy_q;
   logic             done_q;
   logic             stim_q;
   logic             neg_q;

   always_comb begin
      width_d = width_q;
      gap_d   = gap_q;
      count_d = count_q;
      delay_d = delay_q;
      if (cfg_we && (state_q == S_IDLE)) begin
         case (cfg_addr)
            2'd0: width_d = cfg_wdata;
            2'd1: gap_d   = cfg_wdata;
            2'd2: count_d = cfg_wdata[NUM_W-1:0];
            2'd3: delay_d = cfg_wdata;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         width_q <= '0;
         gap_q   <= '0;
         count_q <= '0;
         delay_q <= '0;
      end else begin
         width_q <= width_d;
         gap_q   <= gap_d;
         count_q <= count_d;
         delay_q <= delay_d;
      end
   end

   // Counters hold "remaining cycles minus one"; a phase ends on the cycle cnt_q is zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= S_IDLE;
         width_sh_q    <= '0;
         gap_rl_sh_q   <= '0;
         last_idx_sh_q <= '0;
         cnt_q         <= '0;
         idx_q         <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         stim_q        <= 1'b0;
         neg_q         <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start && !abort) begin
                  width_sh_q    <= width_q;
                  gap_rl_sh_q   <= (gap_q == '0) ? '0 : gap_q - ONE_C;
                  last_idx_sh_q <= count_q - ONE_N;
                  if ((count_q == '0) || (width_q == '0)) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     idx_q  <= '0;
                     busy_q <= 1'b1;
                     if (delay_q != '0) begin
                        state_q <= S_DELAY;
                        cnt_q   <= delay_q - ONE_C;
                     end else begin
                        state_q <= S_PULSE;
                        stim_q  <= 1'b1;
                        cnt_q   <= width_q - ONE_C;
                     end
                  end
               end
            end
            S_DELAY: begin
               if (abort) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end else if (cnt_q != '0) begin
                  cnt_q <= cnt_q - ONE_C;
               end else begin
                  state_q <= S_PULSE;
                  stim_q  <= 1'b1;
                  cnt_q   <= width_sh_q - ONE_C;
               end
            end
            S_PULSE: begin
               if (abort) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                  stim_q  <= 1'b0;
               end else if (cnt_q != '0) begin
                  cnt_q <= cnt_q - ONE_C;
               end else begin
                  stim_q <= 1'b0;
`ifdef STIM_BIPHASIC_EN
                  state_q <= S_NEG;
                  neg_q   <= 1'b1;
                  cnt_q   <= width_sh_q - ONE_C;
`else
                  if (idx_q == last_idx_sh_q) begin
                     state_q <= S_DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= S_GAP;
                     cnt_q   <= gap_rl_sh_q;
                  end
`endif
               end
            end
`ifdef STIM_BIPHASIC_EN
            S_NEG: begin
               if (abort) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                  neg_q   <= 1'b0;
               end else if (cnt_q != '0) begin
                  cnt_q <= cnt_q - ONE_C;
               end else begin
                  neg_q <= 1'b0;
                  if (idx_q == last_idx_sh_q) begin
                     state_q <= S_DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= S_GAP;
                     cnt_q   <= gap_rl_sh_q;
                  end
               end
            end
`endif
            S_GAP: begin
               if (abort) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end else if (cnt_q != '0) begin
                  cnt_q <= cnt_q - ONE_C;
               end else begin
                  state_q <= S_PULSE;
                  stim_q  <= 1'b1;
                  idx_q   <= idx_q + ONE_N;
                  cnt_q   <= width_sh_q - ONE_C;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               stim_q  <= 1'b0;
               neg_q   <= 1'b0;
            end
         endcase
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign stim_out  = stim_q;
   assign pulse_idx = idx_q;
`ifdef STIM_BIPHASIC_EN
   assign stim_neg  = neg_q;
`else
   logic unused_neg;
   assign unused_neg = neg_q;
`endif

endmodule

// File: tb/tb_stim_sequencer.sv
// tb/tb_stim_sequencer.sv - scoreboard bench for stim_sequencer (STIM_BIPHASIC_EN adds NEG checks)
module tb_stim_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        cfg_we;
   logic [1:0]  cfg_addr;
   logic [15:0] cfg_wdata;
   logic        start;
   logic        abort;
   logic        busy;
   logic        done;
   logic        stim_out;
   logic [7:0]  pulse_idx;
   logic        stim_neg_w;

   always #5 clk = ~clk;

   stim_sequencer #(.CNT_W(16), .NUM_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .cfg_we    (cfg_we),
      .cfg_addr  (cfg_addr),
      .cfg_wdata (cfg_wdata),
      .start     (start),
      .abort     (abort),
      .busy      (busy),
      .done      (done),
      .stim_out  (stim_out),
`ifdef STIM_BIPHASIC_EN
      .stim_neg  (stim_neg_w),
`endif
      .pulse_idx (pulse_idx)
   );
`ifndef STIM_BIPHASIC_EN
   assign stim_neg_w = 1'b0;
`endif

   typedef struct packed {
      logic       stim;
      logic       neg;
      logic       busy;
      logic       done;
      logic [7:0] idx;
   } exp_t;

   exp_t       q[$];
   int         n_cmp  = 0;
   int         n_fail = 0;
   logic [7:0] last_idx = 8'd0;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_e(input logic s, input logic n, input logic b, input logic d, input logic [7:0] i);
      exp_t e;
      e.stim = s; e.neg = n; e.busy = b; e.done = d; e.idx = i;
      q.push_back(e);
   endtask

   // Expected per-cycle outputs of a whole train, starting the cycle after start is sampled.
   task automatic push_train(input int w, input int g, input int c, input int d);
      if (c == 0 || w == 0) begin
         push_e(0, 0, 0, 1, last_idx);
      end else begin
         for (int k = 0; k < d; k++) push_e(0, 0, 1, 0, 8'd0);
         for (int p = 0; p < c; p++) begin
            for (int k = 0; k < w; k++) push_e(1, 0, 1, 0, p[7:0]);
`ifdef STIM_BIPHASIC_EN
            for (int k = 0; k < w; k++) push_e(0, 1, 1, 0, p[7:0]);
`endif
            if (p < c - 1)
               for (int k = 0; k < ((g == 0) ? 1 : g); k++) push_e(0, 0, 1, 0, p[7:0]);
         end
         last_idx = 8'(c - 1);
         push_e(0, 0, 0, 1, last_idx);
      end
      push_e(0, 0, 0, 0, last_idx);
   endtask

   task automatic drain(input int n);
      exp_t e;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         start  = 1'b0;
         abort  = 1'b0;
         cfg_we = 1'b0;
         if (q.size() == 0) begin
            chk("scoreboard_empty", 16'd1, 16'd0);
            return;
         end
         e = q.pop_front();
         chk("stim_out", {15'd0, stim_out}, {15'd0, e.stim});
         chk("busy", {15'd0, busy}, {15'd0, e.busy});
         chk("done", {15'd0, done}, {15'd0, e.done});
         chk("pulse_idx", {8'd0, pulse_idx}, {8'd0, e.idx});
`ifdef STIM_BIPHASIC_EN
         chk("stim_neg", {15'd0, stim_neg_w}, {15'd0, e.neg});
         chk("no_overlap", {15'd0, stim_out & stim_neg_w}, 16'd0);
`endif
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [15:0] d);
      cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   task automatic program_regs(input int w, input int g, input int c, input int d);
      wr(2'd0, 16'(w));
      wr(2'd1, 16'(g));
      wr(2'd2, 16'(c));
      wr(2'd3, 16'(d));
   endtask

   task automatic run_train(input int w, input int g, input int c, input int d);
      program_regs(w, g, c, d);
      start = 1'b1;
      push_train(w, g, c, d);
      drain(q.size());
   endtask

   initial begin
      rst = 1'b0; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = 16'd0;
      start = 1'b0; abort = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_busy", {15'd0, busy}, 16'd0);
      chk("reset_done", {15'd0, done}, 16'd0);
      chk("reset_stim", {15'd0, stim_out}, 16'd0);
      chk("reset_idx", {8'd0, pulse_idx}, 16'd0);
      rst = 1'b1;
      @(negedge clk);

      // Basic train, then reset mid-run.
      run_train(3, 2, 4, 0);
      program_regs(3, 2, 4, 0);
      start = 1'b1;
      push_train(3, 2, 4, 0);
      drain(5);
      #2 rst = 1'b0;
      #1;
      chk("async_rst_stim", {15'd0, stim_out}, 16'd0);
      chk("async_rst_busy", {15'd0, busy}, 16'd0);
      chk("async_rst_idx", {8'd0, pulse_idx}, 16'd0);
      q.delete();
      last_idx = 8'd0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      start = 1'b1;
      push_train(0, 0, 0, 0);
      drain(q.size());

      // Delay with GAP=0.
      run_train(1, 0, 3, 5);

      // Abort on the 2nd cycle of pulse 2.
      program_regs(4, 4, 10, 0);
      start = 1'b1;
      push_train(4, 4, 10, 0);
      drain(18);
      abort = 1'b1;
      q.delete();
      last_idx = 8'd2;
      for (int k = 0; k < 6; k++) push_e(0, 0, 0, 0, 8'd2);
      drain(6);

      // COUNT=0 degenerate request.
      run_train(3, 1, 0, 0);

      // Config write and start while busy are both ignored.
      program_regs(2, 1, 2, 0);
      start = 1'b1;
      push_train(2, 1, 2, 0);
      drain(2);
      cfg_we = 1'b1; cfg_addr = 2'd0; cfg_wdata = 16'd5;
      drain(2);
      start = 1'b1;
      drain(q.size());
      start = 1'b1;
      push_train(2, 1, 2, 0);
      drain(q.size());

      // start and abort together in IDLE.
      start = 1'b1;
      abort = 1'b1;
      for (int k = 0; k < 3; k++) push_e(0, 0, 0, 0, last_idx);
      drain(3);

      // Full pulse count without index wrap.
      run_train(1, 0, 255, 0);

`ifdef STIM_BIPHASIC_EN
      run_train(2, 1, 2, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      n_fail++;
      $display("FAIL timeout compared=%0d", n_cmp);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
